// File: rtl/point_spawn_ctrl.sv
// Point spawn controller: respawn delay, spawn search, lifetime and collection.
// Also carries the sprite half-extents used by the collision test.
package vga_pkg;
    localparam int POINT_SIZE  = 8;
    localparam int PLAYER_SIZE = 16;
endpackage

module point_spawn_ctrl
    import vga_pkg::*;
#(
    parameter int RESPAWN_DELAY = 1000,
    parameter int LIFETIME      = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    input  logic [9:0] gen_x,
    input  logic [9:0] gen_y,
    input  logic       gen_active,
    output logic [9:0] point_x,
    output logic [9:0] point_y,
    output logic       point_visible,
    output logic [7:0] score,
    output logic       collected,
    output logic       expired
);

    typedef enum logic [1:0] {IDLE, DELAY, SEEK, ACTIVE} state_t;

    localparam logic [10:0] REACH = 11'(POINT_SIZE + PLAYER_SIZE);
    // A zero delay still spends one cycle in DELAY before searching.
    localparam logic [31:0] DLY_LAST =
        (RESPAWN_DELAY > 0) ? 32'(RESPAWN_DELAY - 1) : 32'd0;
    localparam logic [31:0] LIFE_LAST =
        (LIFETIME > 0) ? 32'(LIFETIME - 1) : 32'd0;

    state_t      state_q, state_d;
    logic [31:0] dly_q, dly_d;
    logic [31:0] life_q, life_d;
    logic [9:0]  px_q, px_d;
    logic [9:0]  py_q, py_d;
    logic        vis_q, vis_d;
    logic [7:0]  score_q, score_d;
    logic        col_q, col_d;
    logic        exp_q, exp_d;

    logic [10:0] dx, dy;
    logic        hit;

    always_comb begin
        dx = (px_q >= player_x) ? ({1'b0, px_q} - {1'b0, player_x})
                                : ({1'b0, player_x} - {1'b0, px_q});
        dy = (py_q >= player_y) ? ({1'b0, py_q} - {1'b0, player_y})
                                : ({1'b0, player_y} - {1'b0, py_q});
        hit = (dx <= REACH) && (dy <= REACH);
    end

    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        life_d  = life_q;
        px_d    = px_q;
        py_d    = py_q;
        vis_d   = vis_q;
        score_d = score_q;
        col_d   = 1'b0;
        exp_d   = 1'b0;

        // start overrides every other event in every state
        if (start) begin
            state_d = DELAY;
            dly_d   = '0;
            life_d  = '0;
            vis_d   = 1'b0;
            score_d = '0;
        end else begin
            unique case (state_q)
                IDLE: ;
                DELAY: begin
                    if (dly_q == DLY_LAST) begin
                        state_d = SEEK;
                        dly_d   = '0;
                    end else begin
                        dly_d = dly_q + 32'd1;
                    end
                end
                SEEK: begin
                    if (gen_active) begin
                        px_d    = gen_x;
                        py_d    = gen_y;
                        vis_d   = 1'b1;
                        life_d  = '0;
                        state_d = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (hit) begin
                        col_d   = 1'b1;
                        vis_d   = 1'b0;
                        dly_d   = '0;
                        state_d = DELAY;
                        if (score_q != 8'hFF) score_d = score_q + 8'd1;
                    end else if (life_q == LIFE_LAST) begin
                        exp_d   = 1'b1;
                        vis_d   = 1'b0;
                        dly_d   = '0;
                        state_d = DELAY;
                    end else begin
                        life_d = life_q + 32'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dly_q   <= '0;
            life_q  <= '0;
            px_q    <= '0;
            py_q    <= '0;
            vis_q   <= 1'b0;
            score_q <= '0;
            col_q   <= 1'b0;
            exp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            life_q  <= life_d;
            px_q    <= px_d;
            py_q    <= py_d;
            vis_q   <= vis_d;
            score_q <= score_d;
            col_q   <= col_d;
            exp_q   <= exp_d;
        end
    end

    assign point_x       = px_q;
    assign point_y       = py_q;
    assign point_visible = vis_q;
    assign score         = score_q;
    assign collected     = col_q;
    assign expired       = exp_q;

endmodule

// File: tb/tb_point_spawn_ctrl.sv
// Bench for point_spawn_ctrl: directed scenarios plus random play
// against a phase/age reference model.
module tb_point_spawn_ctrl;
    import vga_pkg::*;

    localparam int RD    = 4;
    localparam int LT    = 8;
    localparam int REACH = POINT_SIZE + PLAYER_SIZE;

    logic       clk = 1'b0;
    logic       rst, start, gen_active;
    logic [9:0] player_x, player_y, gen_x, gen_y;
    logic [9:0] point_x, point_y;
    logic       point_visible, collected, expired;
    logic [7:0] score;

    point_spawn_ctrl #(.RESPAWN_DELAY(RD), .LIFETIME(LT)) dut (
        .clk(clk), .rst(rst), .start(start),
        .player_x(player_x), .player_y(player_y),
        .gen_x(gen_x), .gen_y(gen_y), .gen_active(gen_active),
        .point_x(point_x), .point_y(point_y),
        .point_visible(point_visible), .score(score),
        .collected(collected), .expired(expired)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: phase 0 idle, 1 waiting, 2 searching, 3 shown
    int m_ph, m_wait, m_age, m_px, m_py, m_score;
    bit m_vis, m_col, m_exp;

    task automatic m_reset();
        m_ph = 0; m_wait = 0; m_age = 0;
        m_px = 0; m_py = 0; m_score = 0;
        m_vis = 0; m_col = 0; m_exp = 0;
    endtask

    function automatic bit near(int a, int b);
        return ((a > b) ? a - b : b - a) <= REACH;
    endfunction

    task automatic model_edge();
        bit hit;
        m_col = 0;
        m_exp = 0;
        if (rst) begin
            m_reset();
            return;
        end
        if (start) begin
            m_score = 0; m_vis = 0; m_ph = 1; m_wait = 0; m_age = 0;
            return;
        end
        case (m_ph)
            1: begin
                m_wait++;
                if (m_wait >= ((RD < 1) ? 1 : RD)) m_ph = 2;
            end
            2: if (gen_active) begin
                m_px = int'(gen_x); m_py = int'(gen_y);
                m_vis = 1; m_age = 0; m_ph = 3;
            end
            3: begin
                hit = near(m_px, int'(player_x)) && near(m_py, int'(player_y));
                if (hit) begin
                    m_col = 1;
                    if (m_score < 255) m_score++;
                    m_vis = 0; m_ph = 1; m_wait = 0;
                end else if (m_age + 1 >= LT) begin
                    m_exp = 1; m_vis = 0; m_ph = 1; m_wait = 0;
                end else begin
                    m_age++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("point_x", 32'(point_x), 32'(m_px));
        chk("point_y", 32'(point_y), 32'(m_py));
        chk("visible", 32'(point_visible), 32'(m_vis));
        chk("score", 32'(score), 32'(m_score));
        chk("collected", 32'(collected), 32'(m_col));
        chk("expired", 32'(expired), 32'(m_exp));
        chk("pulse_excl", 32'(collected & expired), 32'd0);
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    int n;
    int np;

    initial begin
        rst = 1'b1; start = 1'b0; gen_active = 1'b0;
        player_x = '0; player_y = '0; gen_x = '0; gen_y = '0;
        m_reset();
        repeat (3) cyc();
        chk("rst_score", 32'(score), 32'd0);

        @(negedge clk);
        rst = 1'b0;
        gen_active = 1'b1; gen_x = 10'd50; gen_y = 10'd60;
        repeat (5) cyc();
        chk("idle_ignores", 32'(point_visible), 32'd0);

        // first spawn: 4 waiting cycles, then latch
        gen_x = 10'd320; gen_y = 10'd256;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("spawn_not_yet", 32'(point_visible), 32'd0);
        cyc();
        chk("spawn_x", 32'(point_x), 32'd320);
        chk("spawn_y", 32'(point_y), 32'd256);
        chk("spawn_vis", 32'(point_visible), 32'd1);
        chk("spawn_score", 32'(score), 32'd0);

        // just outside reach, then exactly at reach
        player_x = 10'(320 + REACH + 1); player_y = 10'd256;
        cyc();
        chk("reach_plus1", 32'(collected), 32'd0);
        player_x = 10'(320 + REACH);
        cyc();
        chk("collect_pulse", 32'(collected), 32'd1);
        chk("collect_score", 32'(score), 32'd1);
        chk("collect_vis", 32'(point_visible), 32'd0);
        cyc();
        chk("collect_once", 32'(collected), 32'd0);

        // lifetime expiry with player far away
        player_x = 10'd0; player_y = 10'd0;
        gen_x = 10'd500; gen_y = 10'd400;
        n = 0;
        while (!point_visible && n < 20) begin cyc(); n++; end
        chk("life_spawned", 32'(point_visible), 32'd1);
        n = 0;
        while (!expired && n < 20) begin cyc(); n++; end
        chk("life_cycles", 32'(n), 32'(LT));
        chk("life_score", 32'(score), 32'd1);

        // search with no valid candidate for 50 cycles
        gen_active = 1'b0; gen_x = 10'd100; gen_y = 10'd100;
        repeat (RD + 50) cyc();
        chk("seek_hold", 32'(point_x), 32'd500);
        chk("seek_invis", 32'(point_visible), 32'd0);
        gen_active = 1'b1; gen_x = 10'd111; gen_y = 10'd122;
        cyc();
        chk("seek_latch", 32'(point_x), 32'd111);

        // reach score 5, then restart mid-shown
        player_x = 10'd111; player_y = 10'd122;
        n = 0;
        while (score != 8'd5 && n < 80) begin cyc(); n++; end
        chk("score5", 32'(score), 32'd5);
        player_x = 10'd0; player_y = 10'd0;
        gen_x = 10'd600; gen_y = 10'd400;
        n = 0;
        while (!point_visible && n < 20) begin cyc(); n++; end
        cyc();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_vis", 32'(point_visible), 32'd0);
        chk("restart_col", 32'(collected), 32'd0);
        chk("restart_exp", 32'(expired), 32'd0);
        cyc();

        // asynchronous reset between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        m_reset();
        check_all();
        chk("async_px", 32'(point_x), 32'd0);
        repeat (2) cyc();
        @(negedge clk);
        rst = 1'b0;

        // random play
        repeat (3000) begin
            start = ($urandom_range(0, 99) == 0);
            gen_active = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                gen_x = 10'($urandom); gen_y = 10'($urandom);
                player_x = 10'($urandom); player_y = 10'($urandom);
            end else begin
                gen_x = 10'(300 + $urandom_range(0, 60));
                gen_y = 10'(200 + $urandom_range(0, 60));
                player_x = 10'(300 + $urandom_range(0, 60));
                player_y = 10'(200 + $urandom_range(0, 60));
            end
            cyc();
        end

        // saturation at 255
        player_x = 10'd200; player_y = 10'd200;
        gen_x = 10'd200; gen_y = 10'd200; gen_active = 1'b1;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (1600) cyc();
        chk("sat_score", 32'(score), 32'd255);
        np = 0;
        repeat (8) begin
            cyc();
            if (collected) np++;
        end
        chk("sat_pulse", 32'(np > 0), 32'd1);
        chk("sat_hold", 32'(score), 32'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
